// File: rtl/apb_master_nslave_pkg.sv
// Shared types for the N-slave APB master bridge.
// State encoding and slave-index width helper.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    function automatic int sel_width(input int ns);
        return (ns > 1) ? $clog2(ns) : 1;
    endfunction

endpackage

// File: rtl/apb_master_nslave_if.sv
// APB bus between the bridge and its slaves.
// Slave i owns bits [i*DW +: DW] of prdata.
interface apb_master_nslave_if #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int NS = 2
);
    logic [NS-1:0]    psel;
    logic             penable;
    logic             pwrite;
    logic [AW-1:0]    paddr;
    logic [DW-1:0]    pwdata;
    logic [NS*DW-1:0] prdata;
    logic [NS-1:0]    pready;
    logic [NS-1:0]    pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master_nslave_decode.sv
// Address to one-hot slave select.
// Slave index lives in the top address bits.
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int AW = 8,
    parameter int NS = 2
) (
    input  logic [AW-1:0] addr,
    output logic [NS-1:0] sel,
    output logic          valid
);
    localparam int SW = sel_width(NS);

    logic [SW-1:0] idx;
    logic          unused_lo;

    assign idx       = addr[AW-1 -: SW];
    assign unused_lo = ^addr[AW-SW-1:0];

    always_comb begin
        sel   = '0;
        valid = 32'(idx) < 32'(NS);
        for (int i = 0; i < NS; i++) begin
            sel[i] = valid && (32'(idx) == 32'(i));
        end
    end
endmodule

// File: rtl/apb_master_nslave.sv
// APB3 master bridge towards NS slaves with wait states,
// slave error, access timeout and done/error status.
module apb_master_nslave
    import apb_pkg::*;
#(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int NS        = 2,
    parameter int TO_CYCLES = 16
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic                transfer,
    input  logic                read_write,
    input  logic [AW-1:0]       apb_write_paddr,
    input  logic [DW-1:0]       apb_write_data,
    input  logic [AW-1:0]       apb_read_paddr,
    output logic [DW-1:0]       apb_read_data_out,
    output logic                done,
    output logic                error,
    output logic                busy,
    apb_master_nslave_if.master bus
);
    localparam int CW = $clog2(TO_CYCLES + 1);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d, req_addr;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d, rd_mux;
    logic [NS-1:0] sel_q, sel_d, req_sel;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          req_ok, capture, rdy, slv_err;

    assign req_addr = read_write ? apb_read_paddr : apb_write_paddr;

    apb_addr_decode #(
        .AW(AW),
        .NS(NS)
    ) u_dec (
        .addr (req_addr),
        .sel  (req_sel),
        .valid(req_ok)
    );

    // Unselected slaves are masked out of the response
    assign rdy     = |(bus.pready & sel_q);
    assign slv_err = |(bus.pslverr & sel_q);

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NS; i++) begin
            if (sel_q[i]) rd_mux = rd_mux | bus.prdata[i*DW +: DW];
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (transfer && req_ok) begin
                    capture = 1'b1;
                    state_d = SETUP;
                end else if (transfer) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (rdy) begin
                    done_d = 1'b1;
                    err_d  = slv_err;
                    if (!wr_q && !slv_err) rdata_d = rd_mux;
                    if (transfer && req_ok) begin
                        capture = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == CW'(TO_CYCLES - 1)) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (capture) begin
            addr_d  = req_addr;
            wr_d    = !read_write;
            wdata_d = apb_write_data;
            sel_d   = req_sel;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            sel_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.psel          = (state_q != IDLE) ? sel_q : '0;
    assign bus.penable       = (state_q == ACCESS);
    assign bus.pwrite        = wr_q;
    assign bus.paddr         = addr_q;
    assign bus.pwdata        = wdata_q;
    assign busy              = (state_q != IDLE);
    assign done              = done_q;
    assign error             = err_q;
    assign apb_read_data_out = rdata_q;
endmodule
